push_credit_sender: RTL and testbench

- Transmit end of the push-credit interface; drives push_valid/push_data into the CDC flop-RAM FIFO's push side.
- Accepts words from an upstream valid/ready source into a 2-entry staging buffer.
- Launches a word only when it holds a credit, then tracks credits returned by the FIFO.
- Runs entirely in the push_clk domain and handles the post-reset credit initialisation handshake.

---
 rtl/push_credit_sender_if.sv | 37 +++
 rtl/push_credit_sender.sv | 181 ++++++++++++++++++
 tb/tb_push_credit_sender.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/push_credit_sender_if.sv
// ---------------------------------------------------------------------------
// push_credit_sender_if
//
// Purpose : bundles the two handshakes seen by the push-credit sender:
//           the upstream valid/ready word source and the push side of the
//           CDC flop-RAM FIFO (push_valid/push_data out, credits back in).
//
// Signals : in_valid, in_data        upstream word offer
//           in_ready                 sender staging buffer can accept
//           push_valid, push_data    launched word towards the FIFO
//           push_credit              one credit returned per cycle when high
//           push_credit_stall        receiver asks the sender to pause
//
// Modports: master - the sender (push_credit_sender)
//           slave  - the environment around it (source + FIFO)
// ---------------------------------------------------------------------------
interface push_credit_sender_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  push_credit;
    logic                  push_credit_stall;

    modport master (
        input  in_valid, in_data, push_credit, push_credit_stall,
        output in_ready, push_valid, push_data
    );

    modport slave (
        output in_valid, in_data, push_credit, push_credit_stall,
        input  in_ready, push_valid, push_data
    );
endinterface

// File: rtl/push_credit_sender.sv
// ---------------------------------------------------------------------------
// push_credit_sender
//
// Purpose : transmit end of the push-credit interface. Words from an
//           upstream valid/ready source land in a 2-entry staging buffer and
//           are launched towards the FIFO push side only while a credit is
//           held. Credits start at CREDITS after a short INIT sequence that
//           follows reset release and come back one per cycle on push_credit.
//
// Ports   : push_clk               single clock
//           push_rst               asynchronous, active-high reset
//           bus (master modport)   in_valid/in_ready/in_data,
//                                  push_valid/push_data (registered),
//                                  push_credit, push_credit_stall
//           push_sender_in_reset   high during reset and INIT
//           credit_count_push      credits currently held
//           credit_available_push  credits usable for launch
//           credit_overflow        sticky: credit returned while full
//
// Option  : define PUSH_CREDIT_WITHHOLD_EN to add input credit_withhold_push;
//           withheld credits stay counted but cannot be used for launch.
// ---------------------------------------------------------------------------
module push_credit_sender #(
    parameter  int DATA_WIDTH  = 8,
    parameter  int CREDITS     = 16,
    parameter  int INIT_CYCLES = 2,
    localparam int CNT_W       = $clog2(CREDITS + 1)
) (
    input  logic                     push_clk,
    input  logic                     push_rst,
    push_credit_sender_if.master     bus,
    output logic                     push_sender_in_reset,
    output logic [CNT_W-1:0]         credit_count_push,
    output logic [CNT_W-1:0]         credit_available_push,
    output logic                     credit_overflow
`ifdef PUSH_CREDIT_WITHHOLD_EN
    ,
    input  logic [CNT_W-1:0]         credit_withhold_push
`endif
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);

    state_t                state_q, state_d;
    logic [3:0]            init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic                  ovf_q, ovf_d;
    logic                  push_valid_q, push_valid_d;
    logic [DATA_WIDTH-1:0] push_data_q, push_data_d;

    // Staging buffer: two slots addressed by 1-bit pointers, occupancy 0..2.
    logic [DATA_WIDTH-1:0] stage_mem [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  accept;
    logic                  launch;

    // Credit availability seen by the launch decision.
`ifdef PUSH_CREDIT_WITHHOLD_EN
    assign credit_available_push = (credit_q > credit_withhold_push)
                                 ? credit_q - credit_withhold_push
                                 : '0;
`else
    assign credit_available_push = credit_q;
`endif

    assign bus.in_ready = (state_q == ST_RUN) && (occ_q != 2'd2);
    assign accept       = bus.in_valid && bus.in_ready;
    // A credit returned this cycle only counts from the next edge, because
    // the decision looks at the registered count.
    assign launch       = (state_q == ST_RUN) && (occ_q != 2'd0) &&
                          (credit_available_push != '0) && !bus.push_credit_stall;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        credit_d     = credit_q;
        ovf_d        = ovf_q;
        push_valid_d = 1'b0;
        push_data_d  = push_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;

        unique case (state_q)
            ST_INIT: begin
                // push_credit is ignored until the full credit load.
                if (init_cnt_q == INIT_LAST) begin
                    state_d  = ST_RUN;
                    credit_d = CREDITS_C;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end

            ST_RUN: begin
                if (launch) begin
                    push_valid_d = 1'b1;
                    push_data_d  = stage_mem[rd_ptr_q];
                    rd_ptr_d     = ~rd_ptr_q;
                end
                if (accept) begin
                    wr_ptr_d = ~wr_ptr_q;
                end

                unique case ({accept, launch})
                    2'b10:   occ_d = occ_q + 2'd1;
                    2'b01:   occ_d = occ_q - 2'd1;
                    default: occ_d = occ_q;
                endcase

                // Launch and return together cancel out; a return while
                // already full saturates and flags the error.
                unique case ({launch, bus.push_credit})
                    2'b10: credit_d = credit_q - 1'b1;
                    2'b01: begin
                        if (credit_q == CREDITS_C) begin
                            ovf_d = 1'b1;
                        end else begin
                            credit_d = credit_q + 1'b1;
                        end
                    end
                    default: credit_d = credit_q;
                endcase
            end

            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge push_clk or posedge push_rst) begin
        if (push_rst) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            credit_q     <= '0;
            ovf_q        <= 1'b0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            credit_q     <= credit_d;
            ovf_q        <= ovf_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end

    // NOTE: the storage slots carry no reset; occupancy decides which slots
    // hold live words, so clearing the data itself is unnecessary.
    always_ff @(posedge push_clk) begin
        if (accept) begin
            stage_mem[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.push_valid           = push_valid_q;
    assign bus.push_data            = push_data_q;
    assign push_sender_in_reset     = (state_q == ST_INIT);
    assign credit_count_push        = credit_q;
    assign credit_overflow          = ovf_q;

endmodule

// File: tb/tb_push_credit_sender.sv
// ---------------------------------------------------------------------------
// tb_push_credit_sender
//
// Self-checking bench for push_credit_sender. A reference model built from
// queues and integer credit arithmetic predicts every cycle; launched words
// are pushed to a scoreboard queue and a separate monitor pops and compares
// them whenever push_valid is seen. Directed scenarios are followed by a
// randomized phase. Define PUSH_CREDIT_WITHHOLD_EN to cover the option.
// ---------------------------------------------------------------------------
module tb_push_credit_sender;

    localparam int DW = 8;
    localparam int CR = 16;
    localparam int IC = 2;
    localparam int CW = $clog2(CR + 1);

    logic          push_clk = 1'b0;
    logic          push_rst = 1'b1;
    logic          push_sender_in_reset;
    logic [CW-1:0] credit_count_push;
    logic [CW-1:0] credit_available_push;
    logic          credit_overflow;
`ifdef PUSH_CREDIT_WITHHOLD_EN
    logic [CW-1:0] credit_withhold_push = '0;
`endif

    always #5 push_clk = ~push_clk;

    push_credit_sender_if #(.DATA_WIDTH(DW)) ifc ();

    push_credit_sender #(
        .DATA_WIDTH (DW),
        .CREDITS    (CR),
        .INIT_CYCLES(IC)
    ) dut (
        .push_clk             (push_clk),
        .push_rst             (push_rst),
        .bus                  (ifc.master),
        .push_sender_in_reset (push_sender_in_reset),
        .credit_count_push    (credit_count_push),
        .credit_available_push(credit_available_push),
        .credit_overflow      (credit_overflow)
`ifdef PUSH_CREDIT_WITHHOLD_EN
        ,
        .credit_withhold_push (credit_withhold_push)
`endif
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state.
    bit           m_run;
    int           m_init;
    int           m_c;
    bit           m_ovf;
    bit           m_prev;
    bit           m_accepted;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] exp_q[$];
    int           withhold_req = 0;
    int           withhold_cur = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int m_avail();
        return (m_c > withhold_cur) ? m_c - withhold_cur : 0;
    endfunction

    task automatic check_outputs();
        check("in_ready",      ifc.in_ready,          32'(m_run && m_q.size() < 2));
        check("in_reset",      push_sender_in_reset,  32'(!m_run));
        check("credit_count",  credit_count_push,     32'(m_c));
        check("credit_avail",  credit_available_push, 32'(m_avail()));
        check("overflow",      credit_overflow,       32'(m_ovf));
        check("push_valid",    ifc.push_valid,        32'(m_prev));
    endtask

    // Predicts the effect of the coming rising edge from the inputs now driven.
    task automatic model_edge();
        bit launch;
        bit accept;
        m_accepted = 1'b0;
        if (push_rst) return;
        if (!m_run) begin
            m_init++;
            if (m_init == IC) begin
                m_run = 1'b1;
                m_c   = CR;
            end
            m_prev = 1'b0;
            return;
        end
        launch = (m_q.size() > 0) && (m_avail() > 0) && !ifc.push_credit_stall;
        accept = ifc.in_valid && (m_q.size() < 2);
        if (launch) exp_q.push_back(m_q.pop_front());
        if (accept) m_q.push_back(ifc.in_data);
        m_c = m_c - int'(launch) + int'(ifc.push_credit);
        if (m_c > CR) begin
            m_c   = CR;
            m_ovf = 1'b1;
        end
        m_prev     = launch;
        m_accepted = accept;
    endtask

    task automatic step(input bit v, input int d, input bit cr, input bit st);
        @(negedge push_clk);
        check_outputs();
        withhold_cur = withhold_req;
`ifdef PUSH_CREDIT_WITHHOLD_EN
        credit_withhold_push = CW'(withhold_cur);
`endif
        ifc.in_valid          = v;
        ifc.in_data           = DW'(d);
        ifc.push_credit       = cr;
        ifc.push_credit_stall = st;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Offers n words base..base+n-1, each held until the model accepts it.
    task automatic stream(input int n, input int base, input bit st);
        int k = 0;
        for (int c = 0; c < 4 * n + 8 && k < n; c++) begin
            step(1'b1, base + k, 1'b0, st);
            if (m_accepted) k++;
        end
    endtask

    task automatic do_reset();
        @(negedge push_clk);
        push_rst              = 1'b1;
        ifc.in_valid          = 1'b0;
        ifc.in_data           = '0;
        ifc.push_credit       = 1'b0;
        ifc.push_credit_stall = 1'b0;
        #1;
        check("rst_push_valid", ifc.push_valid,         0);
        check("rst_push_data",  ifc.push_data,          0);
        check("rst_in_ready",   ifc.in_ready,           0);
        check("rst_in_reset",   push_sender_in_reset,   1);
        check("rst_credits",    credit_count_push,      0);
        check("rst_overflow",   credit_overflow,        0);
        check("rst_pending",    exp_q.size(),           0);
        m_run = 1'b0; m_init = 0; m_c = 0; m_ovf = 1'b0; m_prev = 1'b0;
        m_q.delete();
        exp_q.delete();
        repeat (2) @(negedge push_clk);
        push_rst = 1'b0;
        check_outputs();
        model_edge();
    endtask

    // Scoreboard monitor: every push_valid pulse must match the oldest
    // predicted launch.
    initial begin
        forever begin
            @(posedge push_clk);
            #1;
            if (ifc.push_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("push_unexpected", exp_q.size(), 1);
                end else begin
                    check("push_data", ifc.push_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses0;
        int w;
        ifc.in_valid          = 1'b0;
        ifc.in_data           = '0;
        ifc.push_credit       = 1'b0;
        ifc.push_credit_stall = 1'b0;

        // Reset release and INIT.
        do_reset();
        idle(1);
        check("init_in_reset_still_high", push_sender_in_reset, 1);
        idle(1);
        check("init_done_credits", credit_count_push, CR);
        check("init_done_in_ready", ifc.in_ready, 1);

        // Stream 20 words without credit returns.
        pulses = 0;
        w = 1;
        for (int k = 0; k < 40; k++) begin
            if (w <= 20) step(1'b1, w, 1'b0, 1'b0);
            else         step(1'b0, 0, 1'b0, 1'b0);
            if (m_accepted) w++;
        end
        idle(2);
        check("stream_pulses",   pulses,            16);
        check("stream_credits",  credit_count_push, 0);
        check("stream_in_ready", ifc.in_ready,      0);
        step(1'b0, 0, 1'b1, 1'b0);
        idle(2);
        check("credit_return_pulses",  pulses,            17);
        check("credit_return_credits", credit_count_push, 0);

        // Same-cycle launch and credit return at credits=5.
        do_reset();
        idle(2);
        stream(11, 'h20, 1'b0);
        idle(3);
        check("pre_same_cycle_credits", credit_count_push, 5);
        step(1'b1, 'h55, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        idle(1);
        check("same_cycle_credits", credit_count_push, 5);
        check("same_cycle_valid",   ifc.push_valid,    1);

        // Stall for 4 cycles with two staged words.
        do_reset();
        idle(2);
        pulses0 = pulses;
        step(1'b1, 'h61, 1'b0, 1'b1);
        step(1'b1, 'h62, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        check("stall_in_ready", ifc.in_ready, 0);
        check("stall_no_launch", pulses, pulses0);
        idle(3);
        check("stall_release_pulses",  pulses,            pulses0 + 2);
        check("stall_release_credits", credit_count_push, 14);

        // Credit return while full sets the sticky overflow.
        do_reset();
        idle(2);
        step(1'b0, 0, 1'b1, 1'b0);
        idle(1);
        check("overflow_set",     credit_overflow,   1);
        check("overflow_credits", credit_count_push, CR);
        idle(4);
        check("overflow_sticky",  credit_overflow,   1);

        // Reset mid-stream with two staged words and credits=7.
        do_reset();
        idle(2);
        stream(9, 'h30, 1'b0);
        idle(3);
        step(1'b1, 'hA1, 1'b0, 1'b1);
        step(1'b1, 'hA2, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        check("mid_credits",  credit_count_push, 7);
        check("mid_in_ready", ifc.in_ready,      0);
        do_reset();
        pulses0 = pulses;
        idle(6);
        check("mid_no_stale", pulses,            pulses0);
        check("mid_credits_after", credit_count_push, CR);

`ifdef PUSH_CREDIT_WITHHOLD_EN
        // Withheld credits are held but not used.
        do_reset();
        idle(2);
        stream(13, 'h40, 1'b0);
        idle(3);
        withhold_req = 3;
        pulses0 = pulses;
        step(1'b1, 'h71, 1'b0, 1'b0);
        step(1'b1, 'h72, 1'b0, 1'b0);
        idle(3);
        check("withhold_avail",    credit_available_push, 0);
        check("withhold_no_launch", pulses,               pulses0);
        withhold_req = 1;
        idle(4);
        check("withhold_two_launch", pulses,            pulses0 + 2);
        check("withhold_credits",    credit_count_push, 1);
        withhold_req = 0;
`endif

        // Randomized traffic.
        do_reset();
        idle(2);
        for (int i = 0; i < 2000; i++) begin
`ifdef PUSH_CREDIT_WITHHOLD_EN
            withhold_req = int'($urandom_range(0, 4));
`endif
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
        withhold_req = 0;
        idle(4);
        @(posedge push_clk);
        #2;
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
